// File: rtl/addsub_arbiter_pkg.sv
// Shared types and constants for the two-requester add/sub arbiter.
package addsub_arbiter_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic idx_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic             sign;
    } op_t;

endpackage

// File: rtl/addsub_arbiter_if.sv
// One requester's request/response channel pair; master = requester side.
interface addsub_arbiter_if;
    import addsub_arbiter_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             req_sub;
    logic             req_sign;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_res;
    logic             rsp_ovf;

    modport master (
        output req_valid, req_a, req_b, req_sub, req_sign, rsp_ready,
        input  req_ready, rsp_valid, rsp_res, rsp_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, req_sign, rsp_ready,
        output req_ready, rsp_valid, rsp_res, rsp_ovf
    );

endinterface

// File: rtl/addsub_arbiter_cla.sv
// Shared 16-bit carry-lookahead add/sub with mode-correct overflow.
// Latency: combinational. Backpressure: none (pure datapath).
// Subtraction is a + ~b + 1; four 4-bit groups with a second lookahead level.
module cla_addsub16
    import addsub_arbiter_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sign,
    output logic [WIDTH-1:0] res,
    output logic             ovf
);

    logic [WIDTH-1:0] bb, g, p;
    logic [WIDTH:0]   c;
    logic [3:0]       gg, gp;
    logic [4:0]       gc;

    always_comb begin
        bb = b ^ {WIDTH{sub}};
        g  = a & bb;
        p  = a ^ bb;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        gc[0] = sub;
        gc[1] = gg[0] | (gp[0] & gc[0]);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[0]);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & gc[0]);
        gc[4] = gg[3] | (gp[3] & gc[3]);
        c = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k] = gc[k];
            for (int j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end
        c[WIDTH] = gc[4];
        res = p ^ c[WIDTH-1:0];
        // Unsigned: carry for add, inverted carry (borrow) for sub.
        ovf = sign ? ((a[WIDTH-1] == bb[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]))
                   : (c[WIDTH] ^ sub);
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub unit between two requesters.
// Latency: response valid one edge after the EXEC cycle; 3 cycles min per op.
// Backpressure: holds in RESP until rsp_ready; both req_ready low outside IDLE.
module addsub_arbiter
    import addsub_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    addsub_arbiter_if.slave       port0,
    addsub_arbiter_if.slave       port1,
    output logic                  busy
);

    state_t                  state, state_nxt;
    idx_t                    ptr, g;
    op_t                     op, op0, op1;
    logic [1:0]              vld, rdy, hs, rsp_rdy, rsp_vld, rsp_ovf;
    logic [1:0][WIDTH-1:0]   rsp_res;
    logic [WIDTH-1:0]        dp_res;
    logic                    dp_ovf;

    assign vld     = {port1.req_valid, port0.req_valid};
    assign rsp_rdy = {port1.rsp_ready, port0.rsp_ready};
    assign op0     = '{a: port0.req_a, b: port0.req_b, sub: port0.req_sub, sign: port0.req_sign};
    assign op1     = '{a: port1.req_a, b: port1.req_b, sub: port1.req_sub, sign: port1.req_sign};

    // Ready never looks at the requester's own valid, only at the competitor's.
    always_comb begin
        rdy[0] = (state == IDLE) && ((ptr == 1'b0) || !vld[1]);
        rdy[1] = (state == IDLE) && ((ptr == 1'b1) || !vld[0]);
        hs     = rdy & vld;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (|hs) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_rdy[g]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= 1'b0;
            g       <= 1'b0;
            op      <= '0;
            rsp_vld <= '0;
            rsp_ovf <= '0;
            rsp_res <= '0;
        end else begin
            if (state == IDLE && |hs) begin
                g  <= hs[1];
                op <= hs[1] ? op1 : op0;
            end
            if (state == EXEC) begin
                rsp_res[g] <= dp_res;
                rsp_ovf[g] <= dp_ovf;
                rsp_vld[g] <= 1'b1;
            end
            if (state == RESP && rsp_rdy[g]) begin
                rsp_vld[g] <= 1'b0;
                ptr        <= ~g;
            end
        end
    end

    cla_addsub16 u_cla (
        .a    (op.a),
        .b    (op.b),
        .sub  (op.sub),
        .sign (op.sign),
        .res  (dp_res),
        .ovf  (dp_ovf)
    );

    assign busy            = (state != IDLE);
    assign port0.req_ready = rdy[0];
    assign port1.req_ready = rdy[1];
    assign port0.rsp_valid = rsp_vld[0];
    assign port1.rsp_valid = rsp_vld[1];
    assign port0.rsp_res   = rsp_res[0];
    assign port1.rsp_res   = rsp_res[1];
    assign port0.rsp_ovf   = rsp_ovf[0];
    assign port1.rsp_ovf   = rsp_ovf[1];

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed table, corner sequences, random vs model.
module tb_addsub_arbiter;
    import addsub_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    addsub_arbiter_if p0();
    addsub_arbiter_if p1();

    addsub_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .port0 (p0),
        .port1 (p1),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int mptr   = 0;

    typedef struct {
        int          idx;
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        sign;
        logic [15:0] res;
        logic        ovf;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: integer arithmetic and range checks, no bit-level carry logic.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic sub, input logic sign);
        int ia, ib, r;
        logic [15:0] res;
        logic ovf;
        if (sign) begin
            ia = int'($signed(a));
            ib = int'($signed(b));
        end else begin
            ia = int'(a);
            ib = int'(b);
        end
        r   = sub ? ia - ib : ia + ib;
        res = r[15:0];
        if (sign) ovf = (r > 32767) || (r < -32768);
        else      ovf = (r > 65535) || (r < 0);
        return {ovf, res};
    endfunction

    function automatic logic get_rdy(input int i);
        return (i == 0) ? p0.req_ready : p1.req_ready;
    endfunction
    function automatic logic get_vld(input int i);
        return (i == 0) ? p0.rsp_valid : p1.rsp_valid;
    endfunction
    function automatic logic [15:0] get_res(input int i);
        return (i == 0) ? p0.rsp_res : p1.rsp_res;
    endfunction
    function automatic logic get_ovf(input int i);
        return (i == 0) ? p0.rsp_ovf : p1.rsp_ovf;
    endfunction

    task automatic set_req(input int idx, input logic v, input logic [15:0] a, input logic [15:0] b,
                           input logic sub, input logic sign);
        if (idx == 0) begin
            p0.req_valid = v; p0.req_a = a; p0.req_b = b; p0.req_sub = sub; p0.req_sign = sign;
        end else begin
            p1.req_valid = v; p1.req_a = a; p1.req_b = b; p1.req_sub = sub; p1.req_sign = sign;
        end
    endtask

    task automatic drop_req(input int idx);
        if (idx == 0) p0.req_valid = 1'b0;
        else          p1.req_valid = 1'b0;
    endtask

    task automatic set_rsp_rdy(input int idx, input logic v);
        if (idx == 0) p0.rsp_ready = v;
        else          p1.rsp_ready = v;
    endtask

    task automatic wait_rdy(input int idx, input string name);
        int n = 0;
        while (!get_rdy(idx) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("%s_accept", name), get_rdy(idx), 1);
    endtask

    // Called #1 after the accepting edge; response handshakes immediately.
    task automatic finish_rsp(input int idx, input logic [16:0] exp, input string name);
        chk($sformatf("%s_exec_vld", name), get_vld(idx), 0);
        chk($sformatf("%s_exec_busy", name), busy, 1);
        chk($sformatf("%s_exec_rdy", name), {p1.req_ready, p0.req_ready}, 0);
        @(posedge clk); #1;
        chk($sformatf("%s_vld", name), get_vld(idx), 1);
        chk($sformatf("%s_res", name), get_res(idx), exp[15:0]);
        chk($sformatf("%s_ovf", name), get_ovf(idx), exp[16]);
        chk($sformatf("%s_other_vld", name), get_vld(1 - idx), 0);
        @(posedge clk); #1;
        chk($sformatf("%s_done_vld", name), get_vld(idx), 0);
        chk($sformatf("%s_done_busy", name), busy, 0);
        mptr = 1 - idx;
    endtask

    task automatic do_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic sign, input logic [16:0] exp, input string name);
        set_req(idx, 1'b1, a, b, sub, sign);
        #1;
        wait_rdy(idx, name);
        @(posedge clk); #1;
        drop_req(idx);
        finish_rsp(idx, exp, name);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mptr = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        set_req(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        set_req(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        p0.rsp_ready = 1'b1;
        p1.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_vld", {p1.rsp_valid, p0.rsp_valid}, 0);
        chk("rst_res0", p0.rsp_res, 0);
        chk("rst_res1", p1.rsp_res, 0);
        chk("rst_ovf", {p1.rsp_ovf, p0.rsp_ovf}, 0);
        chk("rst_rdy", {p1.req_ready, p0.req_ready}, 2'b11);
        rst_n = 1'b1;
        @(posedge clk); #1;

        tbl[0] = '{0, 16'h0123, 16'h0345, 1'b0, 1'b0, 16'h0468, 1'b0};
        tbl[1] = '{1, 16'hF123, 16'h1345, 1'b0, 1'b0, 16'h0468, 1'b1};
        tbl[2] = '{0, 16'hA123, 16'hA345, 1'b0, 1'b1, 16'h4468, 1'b1};
        tbl[3] = '{1, 16'hF123, 16'hF345, 1'b0, 1'b1, 16'hE468, 1'b0};
        tbl[4] = '{0, 16'h2123, 16'hF345, 1'b1, 1'b1, 16'h2DDE, 1'b0};
        tbl[5] = '{0, 16'h0001, 16'h0002, 1'b1, 1'b0, 16'hFFFF, 1'b1};
        tbl[6] = '{1, 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1};
        for (int i = 0; i < 7; i++) begin
            do_op(tbl[i].idx, tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].sign,
                  {tbl[i].ovf, tbl[i].res}, $sformatf("vec%0d", i));
        end

        // Simultaneous requests straight after reset: req0 wins, req1 follows.
        do_reset();
        set_req(0, 1'b1, 16'hF123, 16'h1345, 1'b1, 1'b0);
        set_req(1, 1'b1, 16'h7123, 16'h7345, 1'b0, 1'b1);
        #1;
        chk("sim1_rdy0", p0.req_ready, 1);
        chk("sim1_rdy1", p1.req_ready, 0);
        @(posedge clk); #1;
        drop_req(0);
        finish_rsp(0, {1'b0, 16'hDDDE}, "sim1_r0");
        chk("sim1_rdy1_next", p1.req_ready, 1);
        @(posedge clk); #1;
        drop_req(1);
        finish_rsp(1, {1'b1, 16'hE468}, "sim1_r1");

        // Serve req0 alone so ptr favours req1, then a second pair.
        do_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, {1'b0, 16'h0002}, "solo0");
        set_req(0, 1'b1, 16'h1000, 16'h2000, 1'b0, 1'b0);
        set_req(1, 1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1);
        #1;
        chk("sim2_rdy1", p1.req_ready, 1);
        chk("sim2_rdy0", p0.req_ready, 0);
        @(posedge clk); #1;
        drop_req(1);
        finish_rsp(1, {1'b0, 16'hFFFE}, "sim2_r1");
        wait_rdy(0, "sim2_r0");
        @(posedge clk); #1;
        drop_req(0);
        finish_rsp(0, {1'b0, 16'h3000}, "sim2_r0");

        // Backpressure on rsp0 for 5 cycles with req1 pending.
        p0.rsp_ready = 1'b0;
        set_req(0, 1'b1, 16'h1234, 16'h1111, 1'b1, 1'b0);
        #1;
        wait_rdy(0, "bp");
        @(posedge clk); #1;
        drop_req(0);
        @(posedge clk); #1;
        set_req(1, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_vld", p0.rsp_valid, 1);
            chk("bp_res", p0.rsp_res, 16'h0123);
            chk("bp_busy", busy, 1);
            chk("bp_rdy", {p1.req_ready, p0.req_ready}, 0);
            @(posedge clk); #1;
        end
        drop_req(1);
        p0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_vld", p0.rsp_valid, 0);
        chk("bp_rel_busy", busy, 0);
        chk("bp_rel_res", p0.rsp_res, 16'h0123);
        mptr = 1;

        // Reset during EXEC discards the operation.
        set_req(0, 1'b1, 16'h4000, 16'h4000, 1'b0, 1'b1);
        #1;
        wait_rdy(0, "rstmid");
        @(posedge clk); #1;
        drop_req(0);
        chk("rstmid_exec_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_vld", {p1.rsp_valid, p0.rsp_valid}, 0);
        chk("rstmid_res0", p0.rsp_res, 0);
        chk("rstmid_res1", p1.rsp_res, 0);
        chk("rstmid_ovf", {p1.rsp_ovf, p0.rsp_ovf}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mptr = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rstmid_no_rsp", {busy, p1.rsp_valid, p0.rsp_valid}, 0);
        end
        set_req(0, 1'b1, 16'h0010, 16'h0020, 1'b0, 1'b0);
        set_req(1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        #1;
        chk("rstmid_ptr_rdy0", p0.req_ready, 1);
        chk("rstmid_ptr_rdy1", p1.req_ready, 0);
        drop_req(1);
        @(posedge clk); #1;
        drop_req(0);
        finish_rsp(0, {1'b0, 16'h0030}, "rstmid_new");

        // Random traffic against the model, with round-robin tracking.
        do_reset();
        for (int it = 0; it < 150; it++) begin
            int v, w, k;
            logic [15:0] a0, b0, a1, b1;
            logic s0, g0, s1, g1;
            logic [16:0] exp;
            v  = $urandom_range(1, 3);
            a0 = 16'($urandom); b0 = 16'($urandom); s0 = 1'($urandom); g0 = 1'($urandom);
            a1 = 16'($urandom); b1 = 16'($urandom); s1 = 1'($urandom); g1 = 1'($urandom);
            set_req(0, v[0], a0, b0, s0, g0);
            set_req(1, v[1], a1, b1, s1, g1);
            #1;
            w = (v == 3) ? mptr : ((v == 1) ? 0 : 1);
            chk("rnd_win_rdy", get_rdy(w), 1);
            if (v == 3) chk("rnd_lose_rdy", get_rdy(1 - w), 0);
            @(posedge clk); #1;
            drop_req(0);
            drop_req(1);
            chk("rnd_exec_vld", {p1.rsp_valid, p0.rsp_valid}, 0);
            @(posedge clk); #1;
            exp = (w == 0) ? model(a0, b0, s0, g0) : model(a1, b1, s1, g1);
            chk("rnd_vld", get_vld(w), 1);
            chk("rnd_res", get_res(w), exp[15:0]);
            chk("rnd_ovf", get_ovf(w), exp[16]);
            chk("rnd_other_vld", get_vld(1 - w), 0);
            k = $urandom_range(0, 2);
            if (k > 0) begin
                set_rsp_rdy(w, 1'b0);
                repeat (k) begin
                    @(posedge clk); #1;
                    chk("rnd_hold_vld", get_vld(w), 1);
                end
                set_rsp_rdy(w, 1'b1);
            end
            @(posedge clk); #1;
            chk("rnd_done_vld", get_vld(w), 0);
            mptr = 1 - w;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
